// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the MEM stage and a handshaked
// data-memory port. Checks alignment, forms word address / byte enables /
// lane-replicated write data, holds the request until ack or timeout, and
// returns extended load data with a one-cycle done pulse.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [2:0]  op_q, op_nx;
    logic [1:0]  off_q, off_nx;
    logic        req_nx, we_nx, done_nx, adel_nx, ades_nx, berr_nx;
    logic [31:0] addr_nx, wdata_nx, rdata_nx;
    logic [3:0]  be_nx;

    logic        is_store, misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec, load_data;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Decode the incoming instruction: alignment, byte enables, write data.
    always_comb begin
        is_store   = (op >= OP_SW);
        misaligned = 1'b0;
        be_dec     = '0;
        wdata_dec  = '0;
        case (op)
            OP_LW:         misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU: misaligned = addr[0];
            OP_SW: begin
                misaligned = (addr[1:0] != 2'b00);
                be_dec     = 4'b1111;
                wdata_dec  = wd;
            end
            OP_SH: begin
                misaligned = addr[0];
                be_dec     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_dec  = {2{wd[15:0]}};
            end
            OP_SB: begin
                be_dec    = 4'b0001 << addr[1:0];
                wdata_dec = {4{wd[7:0]}};
            end
            default: ;
        endcase
    end

    // Extract and extend the load result using the latched byte offset.
    always_comb begin
        half_sel = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (off_q)
            2'd0:    byte_sel = dm_rdata[7:0];
            2'd1:    byte_sel = dm_rdata[15:8];
            2'd2:    byte_sel = dm_rdata[23:16];
            default: byte_sel = dm_rdata[31:24];
        endcase
        case (op_q)
            OP_LW:   load_data = dm_rdata;
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = '0;
        endcase
    end

    // Next-state and next-output logic; all outputs except stall are registered.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        off_nx   = off_q;
        req_nx   = dm_req;
        we_nx    = dm_we;
        addr_nx  = dm_addr;
        be_nx    = dm_be;
        wdata_nx = dm_wdata;
        rdata_nx = rdata;
        done_nx  = 1'b0;
        adel_nx  = adel;
        ades_nx  = ades;
        berr_nx  = bus_err;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (misaligned) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        adel_nx  = ~is_store;
                        ades_nx  = is_store;
                        berr_nx  = 1'b0;
                        rdata_nx = '0;
                    end else begin
                        state_nx = REQ;
                        cnt_nx   = '0;
                        op_nx    = op;
                        off_nx   = addr[1:0];
                        req_nx   = 1'b1;
                        we_nx    = is_store;
                        addr_nx  = {addr[31:2], 2'b00};
                        be_nx    = be_dec;
                        wdata_nx = wdata_dec;
                    end
                end
            end
            REQ: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (dm_ack) begin
                    state_nx = DONE;
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    rdata_nx = load_data;
                end else if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                    berr_nx  = 1'b1;
                    rdata_nx = '0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                adel_nx  = 1'b0;
                ades_nx  = 1'b0;
                berr_nx  = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            off_q    <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= '0;
            dm_wdata <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            adel     <= 1'b0;
            ades     <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            op_q     <= op_nx;
            off_q    <= off_nx;
            dm_req   <= req_nx;
            dm_we    <= we_nx;
            dm_addr  <= addr_nx;
            dm_be    <= be_nx;
            dm_wdata <= wdata_nx;
            rdata    <= rdata_nx;
            done     <= done_nx;
            adel     <= adel_nx;
            ades     <= ades_nx;
            bus_err  <= berr_nx;
        end
    end

    assign stall = valid & (state != DONE);

endmodule
